// File: rtl/FanMonitorRegs.sv
// Register map and shared types for the fan monitor; the firmware header is generated from this package.
package FanMonitorRegs;

  localparam int REG_ALARM        = 'h000;
  localparam int REG_IRQ_EN       = 'h002;
  localparam int REG_WINDOW_COUNT = 'h004;
  localparam int REG_RPM_BASE     = 'h020;
  localparam int REG_THRESH_BASE  = 'h022;
  localparam int CHANNEL_STRIDE   = 4;

  typedef logic [15:0] rpm_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ALARM,
    SEL_IRQ_EN,
    SEL_WINDOW,
    SEL_RPM,
    SEL_THRESH
  } reg_sel_e;

  // Pulses-per-revolution is restricted to 1, 2 or 4, so the divide is a shift.
  function automatic int ppr_shift(input int ppr);
    return (ppr == 4) ? 2 : ((ppr == 2) ? 1 : 0);
  endfunction

endpackage

// File: rtl/TachChannel.sv
// One tach channel: two-flop synchronizer, stability filter, saturating edge counter and rpm scaling.
module TachChannel
  import FanMonitorRegs::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int PULSES_PER_REV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tach,
  input  logic window_end,
  output rpm_t rpm_scaled
);

  logic        sync_a;
  logic        sync_b;
  logic        level;
  logic        level_d;
  logic [7:0]  stable_cnt;
  logic [15:0] edges;
  logic        rise;
  logic [21:0] product;
  logic [21:0] scaled;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= tach;
      sync_b <= sync_a;
    end
  end

  // The level only moves once the synchronized input has disagreed with it for FILTER_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      level      <= 1'b0;
      level_d    <= 1'b0;
      stable_cnt <= '0;
    end else begin
      level_d <= level;
      if (sync_b == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == 8'(FILTER_CYCLES - 1)) begin
        level      <= sync_b;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end

  assign rise = level & ~level_d;

  // A rise in the terminal cycle belongs to the window that is just starting.
  always_ff @(posedge clk) begin
    if (rst) begin
      edges <= '0;
    end else if (window_end) begin
      edges <= {15'd0, rise};
    end else if (rise && (edges != 16'hffff)) begin
      edges <= edges + 16'd1;
    end
  end

  assign product    = 22'(edges) * 22'd60;
  assign scaled     = product >> ppr_shift(PULSES_PER_REV);
  assign rpm_scaled = (scaled > 22'h00ffff) ? 16'hffff : scaled[15:0];

endmodule

// File: rtl/apb_fan_monitor.sv
// Multi-channel fan tachometer with a one-wait-state APB register file, latched low-rpm alarms and an irq.
module apb_fan_monitor
  import FanMonitorRegs::*;
#(
  parameter int NUM_FANS       = 2,
  parameter int REFCLK_HZ      = 250000000,
  parameter int PULSES_PER_REV = 2,
  parameter int FILTER_CYCLES  = 8,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [15:0]           pwdata,
  output logic [15:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [NUM_FANS-1:0]   fan_tach,
  output logic                  irq
);

  localparam int GATE_W = $clog2(REFCLK_HZ);
  localparam int CH_W   = (NUM_FANS > 1) ? $clog2(NUM_FANS) : 1;

  typedef enum logic {IDLE, RESPOND} apb_state_e;

  apb_state_e            state;
  apb_state_e            state_next;
  logic                  start;
  logic [GATE_W-1:0]     gate_cnt;
  logic                  window_end;
  logic                  window_end_d;
  logic [15:0]           window_count;
  rpm_t                  rpm_scaled [NUM_FANS];
  rpm_t                  rpm        [NUM_FANS];
  rpm_t                  thresh     [NUM_FANS];
  logic [NUM_FANS-1:0]   alarm;
  logic [NUM_FANS-1:0]   irq_en;
  logic [NUM_FANS-1:0]   alarm_set;
  logic [NUM_FANS-1:0]   alarm_clr;
  logic [ADDR_WIDTH-1:0] ch_off;
  logic [ADDR_WIDTH-1:0] ch_idx;
  logic [ADDR_WIDTH-1:0] ch_sub;
  reg_sel_e              dec_sel;
  logic [CH_W-1:0]       dec_ch;
  logic                  dec_err;
  logic [15:0]           dec_rdata;
  reg_sel_e              sel_q;
  logic [CH_W-1:0]       ch_q;
  logic                  wr_q;
  logic [15:0]           wdata_q;
  logic                  write_fire;

  assign window_end = (gate_cnt == GATE_W'(REFCLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt     <= '0;
      window_end_d <= 1'b0;
      window_count <= '0;
    end else begin
      window_end_d <= window_end;
      if (window_end) begin
        gate_cnt     <= '0;
        window_count <= window_count + 16'd1;
      end else begin
        gate_cnt <= gate_cnt + GATE_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_FANS; i++) begin : g_chan
    TachChannel #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .PULSES_PER_REV(PULSES_PER_REV)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .tach      (fan_tach[i]),
      .window_end(window_end),
      .rpm_scaled(rpm_scaled[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FANS; i++) rpm[i] <= '0;
    end else if (window_end) begin
      for (int i = 0; i < NUM_FANS; i++) rpm[i] <= rpm_scaled[i];
    end
  end

  // Address decode happens in the penable cycle; read data is captured then, so a same-cycle rpm update is not seen.
  always_comb begin
    dec_sel   = SEL_NONE;
    ch_off    = paddr - ADDR_WIDTH'(REG_RPM_BASE);
    ch_idx    = ch_off / ADDR_WIDTH'(CHANNEL_STRIDE);
    ch_sub    = ch_off % ADDR_WIDTH'(CHANNEL_STRIDE);
    dec_ch    = CH_W'(ch_idx);
    dec_rdata = '0;
    if (paddr == ADDR_WIDTH'(REG_ALARM)) begin
      dec_sel = SEL_ALARM;
    end else if (paddr == ADDR_WIDTH'(REG_IRQ_EN)) begin
      dec_sel = SEL_IRQ_EN;
    end else if (paddr == ADDR_WIDTH'(REG_WINDOW_COUNT)) begin
      dec_sel = SEL_WINDOW;
    end else if ((paddr >= ADDR_WIDTH'(REG_RPM_BASE)) && (ch_idx < ADDR_WIDTH'(NUM_FANS))) begin
      if (ch_sub == '0) begin
        dec_sel = SEL_RPM;
      end else if (ch_sub == ADDR_WIDTH'(REG_THRESH_BASE - REG_RPM_BASE)) begin
        dec_sel = SEL_THRESH;
      end
    end
    case (dec_sel)
      SEL_ALARM:  dec_rdata = 16'(alarm);
      SEL_IRQ_EN: dec_rdata = 16'(irq_en);
      SEL_WINDOW: dec_rdata = window_count;
      SEL_RPM:    dec_rdata = rpm[dec_ch];
      SEL_THRESH: dec_rdata = thresh[dec_ch];
      default:    dec_rdata = '0;
    endcase
    dec_err = (dec_sel == SEL_NONE) ||
              (pwrite && ((dec_sel == SEL_WINDOW) || (dec_sel == SEL_RPM)));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (psel && penable) begin
          start      = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign pready = (state == RESPOND);

  always_ff @(posedge clk) begin
    if (rst) begin
      prdata  <= '0;
      pslverr <= 1'b0;
      sel_q   <= SEL_NONE;
      ch_q    <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (start) begin
      prdata  <= (pwrite || dec_err) ? 16'h0000 : dec_rdata;
      pslverr <= dec_err;
      sel_q   <= dec_err ? SEL_NONE : dec_sel;
      ch_q    <= dec_ch;
      wr_q    <= pwrite;
      wdata_q <= pwdata;
    end else begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end
  end

  assign write_fire = (state == RESPOND) && wr_q;
  assign alarm_clr  = (write_fire && (sel_q == SEL_ALARM)) ? wdata_q[NUM_FANS-1:0] : '0;

  always_comb begin
    alarm_set = '0;
    for (int i = 0; i < NUM_FANS; i++) begin
      alarm_set[i] = window_end_d && (thresh[i] != '0) && (rpm[i] < thresh[i]);
    end
  end

  // A set arriving together with its W1C is kept, since the clear is applied before the set is ORed in.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm  <= '0;
      irq_en <= '0;
      irq    <= 1'b0;
      for (int i = 0; i < NUM_FANS; i++) thresh[i] <= '0;
    end else begin
      alarm <= (alarm & ~alarm_clr) | alarm_set;
      irq   <= |(alarm & irq_en);
      if (write_fire && (sel_q == SEL_IRQ_EN)) irq_en <= wdata_q[NUM_FANS-1:0];
      if (write_fire && (sel_q == SEL_THRESH)) thresh[ch_q] <= wdata_q;
    end
  end

endmodule

// File: doc/apb_fan_monitor.md
# apb_fan_monitor

Parametrised multi-channel fan tachometer with an APB register interface, replacing the fixed two-channel, non-bus-attached tachometer pair in the management subsystem. It adds:
- a configurable fan count;
- glitch filtering of tach inputs;
- a pulses-per-revolution setting;
- per-fan low-RPM thresholds, with latched alarms and a maskable interrupt.

It attaches as one small-address-space endpoint on the management APB tree, behind a register slice.

## Interface
- NUM_FANS, 2: number of tach channels, 1..16
- REFCLK_HZ, 250000000: clk frequency; the measurement gate window is exactly REFCLK_HZ cycles (1 s)
- PULSES_PER_REV, 2: tach pulses per revolution; legal values are 1, 2, 4
- FILTER_CYCLES, 8: a new tach level must be stable this many clk cycles before it is accepted; 1..255
- ADDR_WIDTH, 10: APB address width
- clk  input  1  system clock; all logic in this domain
- rst  input  1  reset, synchronous, active-high
- apb  APB.completer  16-bit data, ADDR_WIDTH address  register access
- fan_tach  input  NUM_FANS  raw asynchronous tach inputs
- irq  output  1  registered; equals |(alarm & irq_en)

## Operation
Per-channel input conditioning:
- Two-flop synchronizer, then a stability filter with an 8-bit counter.
- The filtered level updates only after the synchronized input has differed from it for FILTER_CYCLES consecutive cycles.
- Each filtered rising edge increments a 16-bit edge counter, which saturates at 0xffff.

Gate window:
- A shared counter runs 0..REFCLK_HZ-1.
- At the terminal count, every channel latches rpm_i = min(0xffff, edges_i*60 >> log2(PULSES_PER_REV)) and clears its edge counter.
- If an edge occurs in the terminal cycle, it counts as 1 in the new window.
- The product edges*60 is computed at 22 bits before the shift and saturation.

Alarm:
- Evaluated in the cycle after the rpm latch.
- If thresh_i != 0 and rpm_i < thresh_i, alarm[i] is set.
- thresh_i == 0 disables the alarm for that channel.

Registers (byte addresses, 16-bit):
- 0x000 ALARM (W1C): latched alarm bits.
- 0x002 IRQ_EN (RW).
- 0x004 WINDOW_COUNT (RO): completed-window counter, wraps at 0xffff.
- 0x020+4i RPM_i (RO).
- 0x022+4i THRESH_i (RW).

APB access rules:
- Bits above NUM_FANS in ALARM and IRQ_EN read 0 and ignore writes.
- pslverr=1 on reads of unmapped addresses, writes to RO registers, or channel index ≥ NUM_FANS.
- An erroring write has no effect. An erroring read returns prdata=0.

Reset values:
- All registers 0, irq=0, pready=0, pslverr=0, prdata=0.
- Gate counter and all filters/edge counters cleared.
- Filtered levels reset to 0, so a tach input high at reset produces no edge.

## Timing
- APB: exactly one wait state.
  - The first cycle with psel&penable registers the decode.
  - pready, prdata and pslverr are asserted in the following cycle for one cycle.
  - Writes take effect on the cycle pready is high.
- Tach edge to counter increment: 2 sync cycles + FILTER_CYCLES + 1.
- Window terminal (cycle T): RPM_i and WINDOW_COUNT update at T+1, alarm at T+2, irq at T+3.
- Simultaneous events:
  - An alarm set and a W1C of the same bit in the same cycle: set wins.
  - An APB read of RPM_i in the update cycle returns the old value.
  - An IRQ_EN write updates irq on the next cycle.
- rst asserted mid-window or mid-APB transfer: everything returns to reset values on the next edge. An in-flight transfer gets no pready; the requester must retry.

## Structure
- Shared package FanMonitorRegs: register offset localparams (REG_ALARM, REG_IRQ_EN, REG_WINDOW_COUNT, REG_RPM_BASE, REG_THRESH_BASE, CHANNEL_STRIDE) and the 16-bit rpm_t typedef; the firmware header is generated from it.
- One sub-module, TachChannel (synchronizer, filter, edge counter, rpm scaling), instantiated NUM_FANS times by a generate loop. The top holds the gate counter, the register file and the APB FSM (IDLE → RESPOND → IDLE).

## Test plan
Bench parameters: REFCLK_HZ=1000, FILTER_CYCLES=2, PULSES_PER_REV=2, NUM_FANS=3.
- fan0 square wave with period 20 cycles → after the first full window RPM_0 reads 1500; fan1 held low → RPM_1 reads 0.
- fan0 with 1-cycle glitches every 7 cycles, otherwise constant → RPM_0 reads 0; period-4 clean toggling → RPM_0 reads 250*30=7500.
- THRESH_1=100, IRQ_EN=0x2, fan1 stalled → ALARM reads 0x2 and irq rises at T+3; W1C 0x2 → ALARM reads 0 and irq falls the next cycle, re-set at the next window.
- W1C of ALARM in the same cycle as an alarm set → bit remains 1.
- Read of 0x02C (channel 3, absent), write to 0x020, read of 0x010 → pslverr=1 each time, prdata=0, registers unchanged; every access shows pready exactly one cycle after the penable cycle.
- rst pulsed at window cycle 500 with fan0 toggling → RPM_0 reads 0 until a full 1000-cycle window completes after reset; WINDOW_COUNT restarts from 0.
